gpx_hit_fifo: RTL

//  Parametrised single-clock FIFO for GPX TDC hit words. Block-RAM store, registered read, valid/ready output stage.

---
 rtl/gpx_hit_fifo_if.sv | 36 +++
 rtl/gpx_hit_fifo.sv | 134 +++++++++++++
 2 files changed

// File: rtl/gpx_hit_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : gpx_hit_fifo_if
// Purpose  : Bus bundle for the GPX hit FIFO. It carries the writer side
//            (wr_en/wr_data/full/almost_full), the reader side
//            (dout/dout_valid/dout_ready), the flush and the status counters.
//            slave  : the FIFO itself.
//            master : the writer and consumer logic that drive the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface gpx_hit_fifo_if #(
  parameter int DW = 32,
  parameter int AW = 9
);
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [AW+1:0] level;
  logic [15:0]   drop_cnt;

  modport slave (
    input  clr, wr_en, wr_data, dout_ready,
    output full, almost_full, dout, dout_valid, level, drop_cnt
  );

  modport master (
    output clr, wr_en, wr_data, dout_ready,
    input  full, almost_full, dout, dout_valid, level, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/gpx_hit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gpx_hit_fifo
// Purpose  : Single-clock FIFO for GPX TDC hit words. Block-RAM store with a
//            registered read feeding a valid/ready output stage. Provides
//            occupancy, almost-full, overflow drop and a synchronous flush.
// Ports    : clk          system clock, posedge
//            rst_n        asynchronous active-low reset
//            bus (slave)  clr, wr_en, wr_data -> full, almost_full
//                         dout, dout_valid <- dout_ready
//                         level (RAM + output stage), drop_cnt
// Option   : GPX_FIFO_DROP_CNT_EN - when defined, builds a saturating
//            dropped-write counter; otherwise drop_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module gpx_hit_fifo #(
  parameter int DW       = 32,
  parameter int AW       = 9,
  parameter int AFULL_TH = 480
) (
  input  logic          clk,
  input  logic          rst_n,
  gpx_hit_fifo_if.slave bus
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW+1:0] LVL_ONE   = {{(AW+1){1'b0}}, 1'b1};
  localparam logic [AW+1:0] AFULL_LVL = AFULL_TH[AW+1:0];

  logic [DW-1:0] mem [0:DEPTH-1];

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW+1:0] level_q, level_d;
  logic          dout_valid_q, dout_valid_d;
  logic          fetch_pend_q, fetch_pend_d;
  logic          almost_full_q;
  logic [DW-1:0] dout_q;

  logic empty_ram;
  logic full;
  logic wr_acc;
  logic fetch;
  logic retire;

  assign empty_ram = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign wr_acc    = bus.wr_en && !full;
  assign retire    = dout_valid_q && bus.dout_ready;
  // One fetch per two cycles at most: the pending flag blocks the cycle
  // right after a fetch, which keeps the read path a single register.
  assign fetch     = !empty_ram && (!dout_valid_q || bus.dout_ready) && !fetch_pend_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    dout_valid_d = dout_valid_q;
    fetch_pend_d = fetch;
    if (bus.clr) begin
      // Flush overrides any same-cycle write, retire or fetch.
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      dout_valid_d = 1'b0;
      fetch_pend_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (fetch)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      // Level spans RAM plus output stage, so it only drops on retire.
      if (wr_acc && !retire)      level_d = level_q + LVL_ONE;
      else if (!wr_acc && retire) level_d = level_q - LVL_ONE;
      // A landing word keeps the stage valid even when the head retires.
      if (fetch)       dout_valid_d = 1'b1;
      else if (retire) dout_valid_d = 1'b0;
    end
  end

  // RAM array: write port only, contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc && !bus.clr) mem[wr_ptr_q[AW-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      dout_valid_q  <= 1'b0;
      fetch_pend_q  <= 1'b0;
      almost_full_q <= 1'b0;
      dout_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      dout_valid_q  <= dout_valid_d;
      fetch_pend_q  <= fetch_pend_d;
      almost_full_q <= (level_d >= AFULL_LVL);
      // Registered RAM read doubles as the output stage; it only updates
      // when the stage is empty or retiring, so dout holds under stall.
      if (bus.clr)    dout_q <= '0;
      else if (fetch) dout_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

`ifdef GPX_FIFO_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (bus.clr) begin
      drop_q <= '0;
    end else if (bus.wr_en && full && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = 16'h0000;
`endif

  assign bus.full        = full;
  assign bus.almost_full = almost_full_q;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.level       = level_q;

endmodule
`default_nettype wire
